// File: rtl/fir_pkg.sv
// fir_pkg
// Shared constants and the scheduler state type for the stereo FIR
// channel scheduler (fir_chan_sched) and its ring-address helper.
//   NUM_COEFF : filter taps handled by the MAC core (must stay <= 1024)
//   SEQ_LEN   : cycles the core's sequencing input is held per pass
//   SMPL_W    : audio sample width
//   RING_AW   : per-channel ring index width (1024 entries per bank)
//   RAM_AW    : sample RAM address width, {bank, index}
//   CNT_W     : width of the pass down-counter
package fir_pkg;

  localparam int NUM_COEFF = 1021;
  localparam int SEQ_LEN   = NUM_COEFF + 1;
  localparam int SMPL_W    = 16;
  localparam int RING_AW   = 10;
  localparam int RAM_AW    = RING_AW + 1;
  localparam int CNT_W     = 11;

  typedef enum logic [3:0] {
    CLR,
    IDLE,
    WR_L,
    WR_R,
    RUN_L,
    GAP_L,
    CAP_L,
    RUN_R,
    GAP_R,
    CAP_R
  } fir_sched_st_t;

endpackage

// File: rtl/fir_ring_addr.sv
// fir_ring_addr
// Address bookkeeping for the two-bank circular sample RAM.
// Ports:
//   clk, rst_n : clock, synchronous active-low reset
//   adv        : advance the ring write pointer by one (new sample pair)
//   clr_step   : advance the RAM-clear counter by one
//   cff_ptr    : current tap index from the MAC core
//   wr_ptr     : ring index of the newest sample pair
//   clr_cnt    : RAM-clear address, spans both banks
//   rd_idx     : ring index of sample x[n-k], i.e. wr_ptr - cff_ptr mod 1024
module fir_ring_addr
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               adv,
  input  logic               clr_step,
  input  logic [RING_AW-1:0] cff_ptr,
  output logic [RING_AW-1:0] wr_ptr,
  output logic [RAM_AW-1:0]  clr_cnt,
  output logic [RING_AW-1:0] rd_idx
);

  // Both counters rely on natural power-of-two wrap: wr_ptr 1023->0,
  // clr_cnt 2047->0 (the scheduler leaves CLR on that same edge).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      clr_cnt <= '0;
    end else begin
      if (adv) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (clr_step) begin
        clr_cnt <= clr_cnt + 1'b1;
      end
    end
  end

  // Modular subtract: the truncation to RING_AW bits is the ring wrap.
  assign rd_idx = wr_ptr - cff_ptr;

endmodule

// File: rtl/fir_chan_sched.sv
// fir_chan_sched
// Time-multiplexes one CORE_FIR MAC engine across left and right audio
// channels. Each accepted sample pair is written into a two-bank ring RAM
// (bank 0 left, bank 1 right), then the core is sequenced for one full
// pass per channel and each filtered result is captured.
// Ports:
//   clk, rst_n      : clock, synchronous active-low reset
//   smpl_vld        : one-cycle pulse, lft_in/rght_in valid
//   lft_in, rght_in : signed input samples
//   sequencing      : registered pass enable to the core
//   cff_ptr         : current tap index from the core
//   smpl_we         : sample RAM write enable
//   smpl_wr_addr    : sample RAM write address {bank, index}
//   smpl_wr_data    : sample RAM write data
//   smpl_rd_addr    : sample RAM read address {active channel, wr_ptr-cff_ptr}
//   flt_smpl_out    : filtered sample from the core
//   lft_out, rght_out : registered filtered outputs
//   out_vld         : one-cycle pulse, both outputs updated
//   busy            : high whenever not IDLE
//   ovr             : sticky overrun flag, cleared only by reset
module fir_chan_sched
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               smpl_vld,
  input  logic [SMPL_W-1:0]  lft_in,
  input  logic [SMPL_W-1:0]  rght_in,
  output logic               sequencing,
  input  logic [RING_AW-1:0] cff_ptr,
  output logic               smpl_we,
  output logic [RAM_AW-1:0]  smpl_wr_addr,
  output logic [SMPL_W-1:0]  smpl_wr_data,
  output logic [RAM_AW-1:0]  smpl_rd_addr,
  input  logic [SMPL_W-1:0]  flt_smpl_out,
  output logic [SMPL_W-1:0]  lft_out,
  output logic [SMPL_W-1:0]  rght_out,
  output logic               out_vld,
  output logic               busy,
  output logic               ovr
);

  fir_sched_st_t      state;
  fir_sched_st_t      state_nxt;
  logic [CNT_W-1:0]   seq_cnt;
  logic [SMPL_W-1:0]  lft_q;
  logic [SMPL_W-1:0]  rght_q;
  logic [RING_AW-1:0] wr_ptr;
  logic [RAM_AW-1:0]  clr_cnt;
  logic [RING_AW-1:0] rd_idx;
  logic               accept;
  logic               rd_chan;
  logic               run_nxt;
  logic               run_entry;

  // A pair is only taken in IDLE; anywhere else it is dropped as overrun.
  assign accept = (state == IDLE) && smpl_vld;

  fir_ring_addr u_ring (
    .clk      (clk),
    .rst_n    (rst_n),
    .adv      (accept),
    .clr_step (state == CLR),
    .cff_ptr  (cff_ptr),
    .wr_ptr   (wr_ptr),
    .clr_cnt  (clr_cnt),
    .rd_idx   (rd_idx)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= CLR;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      CLR:     if (clr_cnt == '1) state_nxt = IDLE;
      IDLE:    if (smpl_vld) state_nxt = WR_L;
      WR_L:    state_nxt = WR_R;
      WR_R:    state_nxt = RUN_L;
      RUN_L:   if (seq_cnt == '0) state_nxt = GAP_L;
      GAP_L:   state_nxt = CAP_L;
      CAP_L:   state_nxt = RUN_R;
      RUN_R:   if (seq_cnt == '0) state_nxt = GAP_R;
      GAP_R:   state_nxt = CAP_R;
      CAP_R:   state_nxt = IDLE;
      default: state_nxt = CLR;
    endcase
  end

  // Sample RAM write port: the clear sweep, then one left and one right
  // write per accepted pair at the freshly advanced ring pointer.
  always_comb begin
    smpl_we      = 1'b0;
    smpl_wr_addr = '0;
    smpl_wr_data = '0;
    unique case (state)
      CLR: begin
        smpl_we      = 1'b1;
        smpl_wr_addr = clr_cnt;
      end
      WR_L: begin
        smpl_we      = 1'b1;
        smpl_wr_addr = {1'b0, wr_ptr};
        smpl_wr_data = lft_q;
      end
      WR_R: begin
        smpl_we      = 1'b1;
        smpl_wr_addr = {1'b1, wr_ptr};
        smpl_wr_data = rght_q;
      end
      default: ;
    endcase
  end

  // The read address follows cff_ptr combinationally so the RAM and the
  // coefficient ROM register the same tap index on the same edge.
  assign rd_chan      = (state == RUN_R) || (state == GAP_R) || (state == CAP_R);
  assign smpl_rd_addr = {rd_chan, rd_idx};
  assign busy         = (state != IDLE);

  assign run_nxt   = (state_nxt == RUN_L) || (state_nxt == RUN_R);
  assign run_entry = run_nxt && (state != RUN_L) && (state != RUN_R);

  // Pass length: load SEQ_LEN-1 on entry to a RUN state and leave when the
  // counter reaches zero, giving exactly SEQ_LEN sequencing cycles.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seq_cnt <= '0;
    end else if (run_entry) begin
      seq_cnt <= CNT_W'(SEQ_LEN - 1);
    end else if ((state == RUN_L) || (state == RUN_R)) begin
      seq_cnt <= seq_cnt - 1'b1;
    end
  end

  // sequencing is registered from the next state so it is high for exactly
  // the RUN cycles and drops on the very edge a reset is sampled.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sequencing <= 1'b0;
      out_vld    <= 1'b0;
      ovr        <= 1'b0;
      lft_out    <= '0;
      rght_out   <= '0;
      lft_q      <= '0;
      rght_q     <= '0;
    end else begin
      sequencing <= run_nxt;
      out_vld    <= (state == CAP_R);
      if (smpl_vld && (state != IDLE)) begin
        ovr <= 1'b1;
      end
      if (state == CAP_L) begin
        lft_out <= flt_smpl_out;
      end
      if (state == CAP_R) begin
        rght_out <= flt_smpl_out;
      end
      if (accept) begin
        lft_q  <= lft_in;
        rght_q <= rght_in;
      end
    end
  end

endmodule
